// File: rtl/io_stim_sequencer.sv
// io_stim_sequencer: on-board stimulus player that stands in for physical
// switches during CPU self-test. A table of {pattern, dwell} entries is
// written while idle. A start pulse emits a CPU reset pulse and then plays
// the table in order, either once or looping.
// Ports:
//   clock, fpga_rst                  - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_pattern/wr_dwell - table entry write (ignored while busy)
//   len_wr/len_data                  - step count load, clamped to DEPTH
//   start/stop/loop_mode             - playback control
//   sw_out, cpu_rst                  - switch vector and CPU reset pulse
//   busy, done                       - playback status
//   step_idx, step_strobe            - current step and first-cycle strobe
module io_stim_sequencer #(
    parameter int unsigned SW_WIDTH   = 24,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       fpga_rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [SW_WIDTH-1:0]        wr_pattern,
    input  logic [DWELL_W-1:0]         wr_dwell,
    input  logic                       len_wr,
    input  logic [$clog2(DEPTH):0]     len_data,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_mode,
    output logic [SW_WIDTH-1:0]        sw_out,
    output logic                       cpu_rst,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       step_strobe
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE, ST_RST_PULSE, ST_PLAY, ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic [SW_WIDTH-1:0] pat_mem   [DEPTH];
    logic [DWELL_W-1:0]  dwell_mem [DEPTH];

    logic [RW-1:0]       rst_cnt_q,   rst_cnt_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                loop_q,      loop_d;
    logic [CW-1:0]       num_steps_q;
    logic [SW_WIDTH-1:0] sw_out_q,    sw_out_d;
    logic                cpu_rst_q,   cpu_rst_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [AW-1:0]       step_idx_q,  step_idx_d;
    logic                step_strobe_q, step_strobe_d;

    logic                go_c, rst_last_c, step_end_c, last_step_c;
    logic                load_step;
    logic [AW-1:0]       load_idx;

    assign go_c        = start && (num_steps_q != '0);
    assign rst_last_c  = (rst_cnt_q == RW'(RST_CYCLES - 1));
    assign step_end_c  = (dwell_cnt_q == '0);
    assign last_step_c = ({1'b0, step_idx_q} == (num_steps_q - CW'(1)));

    // Table storage; not cleared by reset, frozen while playing.
    always_ff @(posedge clock) begin
        if (wr_en && !busy_q) begin
            pat_mem[wr_addr]   <= wr_pattern;
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (fpga_rst) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; stop overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (go_c) state_d = ST_RST_PULSE;
            ST_RST_PULSE:     if (rst_last_c) state_d = ST_PLAY;
            ST_PLAY:          if (step_end_c && last_step_c && !loop_q) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
        if (stop) state_d = ST_IDLE;
    end

    // Output / datapath next values; every output is registered.
    always_comb begin
        rst_cnt_d     = rst_cnt_q;
        dwell_cnt_d   = dwell_cnt_q;
        loop_d        = loop_q;
        sw_out_d      = sw_out_q;
        cpu_rst_d     = cpu_rst_q;
        busy_d        = busy_q;
        done_d        = done_q;
        step_idx_d    = step_idx_q;
        step_strobe_d = 1'b0;
        load_step     = 1'b0;
        load_idx      = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go_c) begin
                    cpu_rst_d  = 1'b1;
                    sw_out_d   = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    step_idx_d = '0;
                    rst_cnt_d  = '0;
                    loop_d     = loop_mode;
                end
            end
            ST_RST_PULSE: begin
                if (rst_last_c) begin
                    cpu_rst_d = 1'b0;
                    load_step = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_PLAY: begin
                if (step_end_c) begin
                    if (!last_step_c) begin
                        load_step = 1'b1;
                        load_idx  = step_idx_q + AW'(1);
                    end else if (loop_q) begin
                        load_step = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end
            default: ;
        endcase

        // Counter holds remaining cycles after the first; dwell 0 acts as 1.
        if (load_step) begin
            step_idx_d    = load_idx;
            sw_out_d      = pat_mem[load_idx];
            step_strobe_d = 1'b1;
            dwell_cnt_d   = (dwell_mem[load_idx] == '0) ? '0
                                                         : dwell_mem[load_idx] - DWELL_W'(1);
        end

        if (stop) begin
            sw_out_d      = '0;
            cpu_rst_d     = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            step_idx_d    = '0;
            step_strobe_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (fpga_rst) begin
            rst_cnt_q     <= '0;
            dwell_cnt_q   <= '0;
            loop_q        <= 1'b0;
            num_steps_q   <= '0;
            sw_out_q      <= '0;
            cpu_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            step_idx_q    <= '0;
            step_strobe_q <= 1'b0;
        end else begin
            rst_cnt_q     <= rst_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
            loop_q        <= loop_d;
            sw_out_q      <= sw_out_d;
            cpu_rst_q     <= cpu_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            step_idx_q    <= step_idx_d;
            step_strobe_q <= step_strobe_d;
            if (len_wr && !busy_q)
                num_steps_q <= (len_data > DEPTH_L) ? DEPTH_L : len_data;
        end
    end

    assign sw_out      = sw_out_q;
    assign cpu_rst     = cpu_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_idx    = step_idx_q;
    assign step_strobe = step_strobe_q;

endmodule

// File: doc/io_stim_sequencer.md
Name: io_stim_sequencer

Overview:
- On-board stimulus player for the CPU top; replaces physical switches during self-test.
- Holds a programmable table of switch vectors, each with its own dwell time.
- On start, emits a CPU reset pulse, then drives the vectors onto the switch bus in order.
- Supports one-shot or looping playback; sits between the switch pins and the top's switch input.

Parameters:
- SW_WIDTH, 24, width of the switch bus / pattern.
- DEPTH, 16, number of table entries (power of two, >=2).
- DWELL_W, 16, width of per-step dwell count in clock cycles.
- RST_CYCLES, 4, length of the CPU reset pulse in cycles (>=1).

Ports:
- clock  in  1  system clock; everything on rising edge.
- fpga_rst  in  1  synchronous active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  log2(DEPTH)  table entry index.
- wr_pattern  in  SW_WIDTH  switch vector for the entry.
- wr_dwell  in  DWELL_W  hold time for the entry in cycles.
- len_wr  in  1  load step count from len_data.
- len_data  in  log2(DEPTH)+1  number of steps to play.
- start  in  1  begin playback (single-cycle pulse).
- stop  in  1  abort playback.
- loop_mode  in  1  1 = wrap to step 0 after the last step; sampled at start.
- sw_out  out  SW_WIDTH  driven switch vector.
- cpu_rst  out  1  reset pulse to the CPU top.
- busy  out  1  high in RST_PULSE and PLAY.
- done  out  1  one-shot playback completed.
- step_idx  out  log2(DEPTH)  index of the step being driven.
- step_strobe  out  1  one-cycle pulse on the first cycle of each step.

Behaviour:
- Reset: sw_out=0, cpu_rst=0, busy=0, done=0, step_idx=0, step_strobe=0, num_steps=0, state IDLE. Table RAM is not cleared.
- Table write: on wr_en, entry[wr_addr] <= {wr_pattern, wr_dwell}. Writes are ignored while busy.
- Step count: on len_wr, num_steps <= min(len_data, DEPTH). len_wr is ignored while busy.
- States: IDLE, RST_PULSE, PLAY, DONE.
- IDLE/DONE -> RST_PULSE on start when num_steps!=0.
  - start with num_steps==0 is ignored.
  - done clears on entry to RST_PULSE.
- RST_PULSE: cpu_rst=1 and sw_out=0 for exactly RST_CYCLES cycles, then PLAY at step 0.
- PLAY:
  - On the first cycle of step k: sw_out=pattern[k], step_idx=k, step_strobe=1.
  - Step is held max(dwell[k],1) cycles; dwell 0 is treated as 1.
  - Then advances to k+1.
- After step num_steps-1:
  - loop_mode latched 1: go to step 0 with no reset pulse and no gap cycle.
  - Otherwise: DONE. sw_out holds the last pattern, done=1, busy=0.
- Timing: start sampled at cycle T -> cpu_rst=1 on cycles T+1..T+RST_CYCLES -> sw_out=pattern[0] and step_strobe at T+RST_CYCLES+1.
- Stop: in any state, next cycle -> IDLE with sw_out=0, cpu_rst=0, busy=0, done=0, step_idx=0.
  - Stop beats start in the same cycle.
  - Stop mid-RST_PULSE truncates the pulse.
- start while busy: ignored.
- Table write during DONE/IDLE: allowed; takes effect on the next start.
- fpga_rst mid-playback: immediate return to reset values at the next edge.
- Dwell counter is DWELL_W bits, loads once per step, and never wraps. Max step = 2^DWELL_W-1 cycles.

Test Plan:
- Load 3 entries {24'h000400,10},{24'h000001,10},{24'h000002,10}; len=3; loop=0; start at T.
  - cpu_rst high T+1..T+4.
  - sw_out=24'h000400 at T+5..T+14, 24'h000001 at T+15..T+24, 24'h000002 from T+25.
  - done=1 at T+35 with sw_out holding 24'h000002.
- Same table with loop=1.
  - After step 2, step_strobe with step_idx=0 and sw_out=24'h000400 at T+35.
  - No further cpu_rst; busy stays 1.
- Dwell=0 entry {24'h010003,0} between two dwell-2 entries -> 24'h010003 driven exactly 1 cycle, with its own step_strobe.
- stop asserted 2 cycles into RST_PULSE, and separately mid-PLAY at step 1 -> next cycle: cpu_rst=0, sw_out=0, busy=0, done=0.
- start with len=0 -> no state change. start while busy -> ignored. wr_en while busy to entry 0 -> entry unchanged on the next run.
- len_data=20 with DEPTH=16 -> plays 16 steps. fpga_rst mid-PLAY -> all outputs 0 on the next cycle.
